dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL be clocked by one clock, clk, and reset by rst, which is synchronous and active-high.
REQ-002 Parameter: STARVE_LIMIT, default 4, max consecutive contested cycles the core may win before the loader is granted.
REQ-003 Ports SHALL be: clk in 1 clock; rst in 1 sync active-high reset.
REQ-004 core_req in 1 MEM-stage access request; core_we in 1 store when 1, load when 0; core_size in 2 00 byte / 01 half / 10 word; core_unsigned in 1 zero-extend loads.
REQ-005 core_addr in 32 byte address; core_wdata in 32 store data (low bytes valid for sub-word); core_rdata out 32 extended load data; core_ready out 1 access complete this cycle; core_misalign out 1 access rejected.
REQ-006 ld_req in 1 loader request; ld_we in 1 loader store; ld_addr in 32 word-aligned address; ld_wdata in 32; ld_rdata out 32 raw word; ld_gnt out 1 loader access performed this cycle.
REQ-007 mem_store out 1 word write strobe; mem_addr out 32; mem_wdata out 32; mem_rdata in 32 combinational read of word mem_addr[31:2].

Function
REQ-008 FSM states SHALL be IDLE and MERGE; only a core sub-word store enters MERGE.
REQ-009 Arbitration in IDLE: core wins when core_req=1, unless starve_cnt==STARVE_LIMIT and ld_req=1, then loader wins.
REQ-010 starve_cnt SHALL increment when core wins with ld_req=1, clear when loader is granted or ld_req=0, and saturate at STARVE_LIMIT.
REQ-011 Misaligned (half with addr[0]=1; word with addr[1:0]!=0): core_misalign=1 and core_ready=1 in the same cycle, no mem_store, memory counts as unused (loader may be granted that cycle).
REQ-012 Core load: mem_addr=core_addr, core_rdata=selected byte/half/word of mem_rdata by addr[1:0], sign- or zero-extended per core_unsigned, core_ready=1 same cycle.
REQ-013 Core word store: mem_store=1, mem_wdata=core_wdata, core_ready=1 same cycle.
REQ-014 Core sub-word store: cycle 1 (IDLE) reads word, latches merged word (lanes selected by addr[1:0]), core_ready=0, goes to MERGE; cycle 2 (MERGE) mem_store=1 with latched word and address, core_ready=1, returns to IDLE.
REQ-015 In MERGE the memory SHALL be held by the core; ld_gnt=0 regardless of ld_req, and starve_cnt increments if ld_req=1.
REQ-016 Core inputs SHALL be held stable by the pipeline while core_ready=0; MERGE uses only latched values.
REQ-017 Loader access: mem_addr=ld_addr, mem_store=ld_we, mem_wdata=ld_wdata, ld_rdata=mem_rdata, ld_gnt=1 same cycle; ld_addr[1:0] ignored.
REQ-018 Granted loader with core_req=1: core_ready=0 that cycle (core stalls).
REQ-019 No request granted: mem_store=0, mem_addr=0, core_ready=0, ld_gnt=0.

Reset
REQ-020 While rst=1 at a clk edge: state<=IDLE, starve_cnt<=0, merge latches<=0.
REQ-021 During any cycle with rst=1, mem_store=0, core_ready=0, ld_gnt=0, core_misalign=0, core_rdata=0, ld_rdata=0.
REQ-022 rst asserted in MERGE SHALL abort the pending write; no mem_store occurs.

Structure
REQ-023 Shared package dmem_pkg SHALL hold size encodings SZ_B/SZ_H/SZ_W, state enum {IDLE, MERGE}, and the default STARVE_LIMIT.
REQ-024 Byte-lane merge and load extraction SHALL be a combinational sub-module lane_mux; arbitration and FSM stay in dmem_arbiter.

Verification
REQ-025 Word at 0x10 = 0x11223344; byte store 0xAB to 0x12 -> ready low 1 cycle, then mem_store of 0x11AB3344 to 0x10, ready high.
REQ-026 Word at 0x20 = 0x0000F0FF; signed half load 0x20 -> core_rdata 0xFFFFF0FF; unsigned byte load 0x21 -> 0x000000F0.
REQ-027 Half load at 0x23 -> core_misalign=1, core_ready=1, no mem_store; concurrent ld_req granted same cycle.
REQ-028 core_req and ld_req held high 6 cycles -> core wins cycles 1-4, loader granted cycle 5, core wins cycle 6.
REQ-029 rst pulsed during MERGE of byte store to 0x30 -> no mem_store, memory word at 0x30 unchanged, state IDLE next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access sizes, FSM states
// and the default loader starvation limit.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    // Bytes are always aligned; any size other than byte/half is treated as word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arbiter_lane_mux.sv
// Combinational byte-lane logic: extracts/extends sub-word loads and builds
// the merged word for sub-word stores from the word currently read.
module lane_mux
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byteShift;
    logic [4:0]  halfShift;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    assign byteShift = {addr_lo_i, 3'b000};
    assign halfShift = {addr_lo_i[1], 4'b0000};
    assign byteVal   = rdata_i[byteShift +: 8];
    assign halfVal   = rdata_i[halfShift +: 16];

    always_comb begin
        load_o = rdata_i;
        case (size_i)
            SZ_B:    load_o = unsigned_i ? {24'h000000, byteVal} : {{24{byteVal[7]}}, byteVal};
            SZ_H:    load_o = unsigned_i ? {16'h0000, halfVal} : {{16{halfVal[15]}}, halfVal};
            default: load_o = rdata_i;
        endcase
    end

    // Only the addressed lanes are replaced; the rest keep the word just read.
    always_comb begin
        merged_o = rdata_i;
        case (size_i)
            SZ_B:    merged_o[byteShift +: 8]  = wdata_i[7:0];
            SZ_H:    merged_o[halfShift +: 16] = wdata_i;
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core MEM stage and a loader,
// with starvation protection for the loader and read-modify-write sub-word stores.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    output logic        core_misalign,

    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] ld_rdata,
    output logic        ld_gnt,

    output logic        mem_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   maddr_q, maddr_d;

    logic [31:0]   loadData;
    logic [31:0]   mergedWord;
    logic          misaligned;
    logic          starved;
    logic          coreGrant;
    logic          ldGrant;
    logic [CW-1:0] starveInc;

    lane_mux u_lane_mux (
        .size_i     (core_size),
        .unsigned_i (core_unsigned),
        .addr_lo_i  (core_addr[1:0]),
        .rdata_i    (mem_rdata),
        .wdata_i    (core_wdata[15:0]),
        .load_o     (loadData),
        .merged_o   (mergedWord)
    );

    assign misaligned = is_misaligned(core_size, core_addr[1:0]);
    assign starved    = (starve_q == LIMIT) && ld_req;
    assign coreGrant  = core_req && !misaligned && !starved;
    assign ldGrant    = ld_req && !coreGrant;
    assign starveInc  = (starve_q == LIMIT) ? LIMIT : starve_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            merge_q  <= '0;
            maddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            merge_q  <= merge_d;
            maddr_q  <= maddr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        merge_d       = merge_q;
        maddr_d       = maddr_q;
        mem_store     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        core_rdata    = '0;
        core_ready    = 1'b0;
        core_misalign = 1'b0;
        ld_rdata      = '0;
        ld_gnt        = 1'b0;

        // Everything is suppressed while in reset, including a pending merge write.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (core_req && misaligned) begin
                        core_misalign = 1'b1;
                        core_ready    = 1'b1;
                    end

                    if (coreGrant) begin
                        mem_addr = core_addr;
                        if (!core_we) begin
                            core_rdata = loadData;
                            core_ready = 1'b1;
                        end else if (core_size == SZ_B || core_size == SZ_H) begin
                            merge_d = mergedWord;
                            maddr_d = {core_addr[31:2], 2'b00};
                            state_d = MERGE;
                        end else begin
                            mem_store  = 1'b1;
                            mem_wdata  = core_wdata;
                            core_ready = 1'b1;
                        end
                    end else if (ldGrant) begin
                        mem_addr  = ld_addr;
                        mem_store = ld_we;
                        mem_wdata = ld_wdata;
                        ld_rdata  = mem_rdata;
                        ld_gnt    = 1'b1;
                    end

                    if (!ld_req || ldGrant) begin
                        starve_d = '0;
                    end else if (coreGrant) begin
                        starve_d = starveInc;
                    end
                end

                MERGE: begin
                    mem_store  = 1'b1;
                    mem_addr   = maddr_q;
                    mem_wdata  = merge_q;
                    core_ready = 1'b1;
                    state_d    = IDLE;
                    starve_d   = ld_req ? starveInc : '0;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
